// File: rtl/instruction_fetch_pkg.sv
// Shared widths, opcode field position, PC step and FSM state type for the fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned PC_W       = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_W   = 11;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 21;

  localparam logic [PC_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/pc_adder.sv
// Sequential-PC incrementer: pc + 4, wrapping modulo 2^64.
module pc_adder
  import instruction_fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_o
);

  assign pc_o = pc_i + PC_INC;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues reads to instruction memory, holds one fetched
// instruction for decode, and handles redirects including those that arrive while
// a read is still outstanding.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [OPCODE_W-1:0] out_opcode
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [PC_W-1:0]    pend_q, pend_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  // Keeps imem_req low during reset and until the first edge after release.
  logic               req_en_q, req_en_d;

  logic               ack;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    rpc;

  pc_adder u_pc_adder (
    .pc_i (addr_q),
    .pc_o (pc_plus4)
  );

  assign imem_req   = req_en_q & (state_q != StHold);
  assign imem_addr  = addr_q;
  assign out_valid  = valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;
  assign out_opcode = out_instr_q[OPCODE_MSB:OPCODE_LSB];

  // An ack only counts while a request is actually on the bus.
  assign ack = imem_ack & imem_req;
  assign rpc = redirect_pc & ~64'h3;

  // Next-state: redirect beats everything, then ack, then decode handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    req_en_d    = 1'b1;

    unique case (state_q)
      StFetch: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          // With no read outstanding (acked now, or none issued yet) retarget directly.
          if (ack || !req_en_q) begin
            addr_d = rpc;
          end else begin
            pend_d  = rpc;
            state_d = StDrain;
          end
        end else if (ack) begin
          out_instr_d = imem_rdata;
          out_pc_d    = addr_q;
          valid_d     = 1'b1;
          addr_d      = pc_plus4;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          addr_d  = rpc;
          state_d = StFetch;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StDrain: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          if (ack) begin
            addr_d  = rpc;
            state_d = StFetch;
          end else begin
            pend_d = rpc;
          end
        end else if (ack) begin
          addr_d  = pend_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      addr_q      <= RESET_PC;
      pend_q      <= '0;
      valid_q     <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      req_en_q    <= req_en_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vector table for the corner cases,
// then randomized memory latency / redirects / back-pressure against a program-flow model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [10:0] out_opcode;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Contents of instruction memory as a function of address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ack, input logic [31:0] rdata, input logic rv,
                     input logic [63:0] rpc, input logic rdy, input logic e_req,
                     input logic [63:0] e_addr, input logic e_valid, input logic [63:0] e_pc,
                     input logic [31:0] e_instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_instr = e_instr;
    vq.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ew;
    logic        p_rv, p_rdy, m_valid, prev_req, prev_ack;
    logic [63:0] p_rpc, exp_pc, prev_addr;
    int          wait_left, deliveries, gap;

    // ack rdata rv rpc rdy | req addr valid pc instr  (outputs seen before this cycle's edge)
    add(1, 32'h1111_1111, 0, 64'h0, 0,   1, 64'h0,   0, 64'h0,   32'h0);
    add(0, 32'h0,         0, 64'h0, 1,   0, 64'h4,   1, 64'h0,   32'h1111_1111);
    add(1, 32'h2222_2222, 0, 64'h0, 0,   1, 64'h4,   0, 64'h0,   32'h0);
    add(0, 32'h0,         0, 64'h0, 1,   0, 64'h8,   1, 64'h4,   32'h2222_2222);
    // redirect to 0x100 while read of 0x8 is pending (3-cycle latency)
    add(0, 32'h0,         1, 64'h100, 0, 1, 64'h8,   0, 64'h0,   32'h0);
    add(0, 32'h0,         0, 64'h0, 0,   1, 64'h8,   0, 64'h0,   32'h0);
    add(1, 32'hDEAD_BEEF, 0, 64'h0, 0,   1, 64'h8,   0, 64'h0,   32'h0);
    add(1, 32'hF840_0000, 0, 64'h0, 0,   1, 64'h100, 0, 64'h0,   32'h0);
    for (int i = 0; i < 5; i++) add(0, 32'h0, 0, 64'h0, 0, 0, 64'h104, 1, 64'h100, 32'hF840_0000);
    add(0, 32'h0,         0, 64'h0, 1,   0, 64'h104, 1, 64'h100, 32'hF840_0000);
    // redirect to 0x40 coincident with ack
    add(1, 32'h3333_3333, 1, 64'h40, 0,  1, 64'h104, 0, 64'h0,   32'h0);
    // two redirects while draining, last wins
    add(0, 32'h0,         1, 64'h200, 0, 1, 64'h40,  0, 64'h0,   32'h0);
    add(0, 32'h0,         1, 64'h300, 0, 1, 64'h40,  0, 64'h0,   32'h0);
    add(1, 32'h4444_4444, 0, 64'h0, 0,   1, 64'h40,  0, 64'h0,   32'h0);
    // misaligned target is forced to word alignment
    add(0, 32'h0,         1, 64'h302, 0, 1, 64'h300, 0, 64'h0,   32'h0);
    add(1, 32'h5555_5555, 0, 64'h0, 0,   1, 64'h300, 0, 64'h0,   32'h0);
    add(1, 32'h6666_6666, 0, 64'h0, 0,   1, 64'h300, 0, 64'h0,   32'h0);
    // redirect together with out_ready in HOLD
    add(0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h304, 1, 64'h300, 32'h6666_6666);
    add(1, 32'h7777_7777, 0, 64'h0, 0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0);
    add(0, 32'h0, 0, 64'h0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_7777);

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_out_instr", 64'(out_instr), 64'h0);
    rst_n = 1'b1;
    #1 check("req_low_before_first_edge", 64'(imem_req), 64'd0);
    @(negedge clk);

    foreach (vq[i]) begin
      imem_ack = vq[i].ack; imem_rdata = vq[i].rdata; redirect_valid = vq[i].rv;
      redirect_pc = vq[i].rpc; out_ready = vq[i].rdy;
      check($sformatf("vec%0d_req", i), 64'(imem_req), 64'(vq[i].e_req));
      check($sformatf("vec%0d_addr", i), imem_addr, vq[i].e_addr);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vq[i].e_valid));
      if (vq[i].e_valid) begin
        ew = vq[i].e_instr;
        check($sformatf("vec%0d_out_pc", i), out_pc, vq[i].e_pc);
        check($sformatf("vec%0d_out_instr", i), 64'(out_instr), 64'(ew));
        check($sformatf("vec%0d_opcode", i), 64'(out_opcode), 64'(ew[31:21]));
        if (ew == 32'hF840_0000) check("ldur_opcode", 64'(out_opcode), 64'h7C2);
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of HOLD.
    imem_ack = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    check("pre_async_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_req", 64'(imem_req), 64'd0);
    check("async_rst_addr", imem_addr, 64'h0);
    @(negedge clk);

    // Randomized phase.
    p_rv = 1'b0; p_rdy = 1'b0; p_rpc = '0; m_valid = 1'b0; prev_req = 1'b0;
    prev_ack = 1'b0; prev_addr = '0; exp_pc = 64'h0; wait_left = -1;
    deliveries = 0; gap = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) begin
        if (p_rv || (m_valid && p_rdy)) begin
          check("rand_valid_drop", 64'(out_valid), 64'd0);
          exp_pc  = p_rv ? (p_rpc & ~64'h3) : exp_pc + 64'd4;
          m_valid = 1'b0;
          gap++;
        end else if (m_valid) begin
          check("rand_valid_hold", 64'(out_valid), 64'd1);
        end else if (out_valid) begin
          check("rand_delivery_after_ack", 64'(prev_req & prev_ack), 64'd1);
          m_valid = 1'b1;
          deliveries++;
          gap = 0;
        end else begin
          gap++;
        end
        if (out_valid) begin
          ew = memf(exp_pc);
          check("rand_out_pc", out_pc, exp_pc);
          check("rand_out_instr", 64'(out_instr), 64'(ew));
          check("rand_opcode", 64'(out_opcode), 64'(ew[31:21]));
        end
        if (prev_req && !prev_ack) begin
          check("rand_req_held", 64'(imem_req), 64'd1);
          check("rand_addr_stable", imem_addr, prev_addr);
        end
        if (gap > 80) begin
          check("rand_liveness_gap", 64'(gap), 64'd0);
          gap = 0;
        end
      end

      out_ready      = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | (redirect_pc & 64'hF);
      if (imem_req) begin
        if (wait_left < 0) wait_left = $urandom_range(0, 2);
        imem_ack = (wait_left == 0);
        wait_left--;
      end else begin
        imem_ack = 1'b0;
      end
      imem_rdata = imem_ack ? memf(imem_addr) : $urandom;

      p_rv = redirect_valid; p_rdy = out_ready; p_rpc = redirect_pc;
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      @(negedge clk);
    end
    check("rand_deliveries_min", 64'(deliveries >= 200), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 64, byte address of the request.
REQ-006 SHALL have port imem_ack, input, 1, read complete; data valid this cycle; may arrive the same cycle as imem_req (zero wait).
REQ-007 SHALL have port imem_rdata, input, 32, instruction word, sampled only when imem_ack=1.
REQ-008 SHALL have port redirect_valid, input, 1, taken branch or flush request from a later stage.
REQ-009 SHALL have port redirect_pc, input, 64, target address, qualified by redirect_valid.
REQ-010 SHALL have port out_valid, output, 1, decode slot holds a valid instruction.
REQ-011 SHALL have port out_ready, input, 1, decode/control stage accepts the slot this cycle.
REQ-012 SHALL have port out_pc, output, 64, address of the held instruction.
REQ-013 SHALL have port out_instr, output, 32, held instruction word.
REQ-014 SHALL have port out_opcode, output, 11, out_instr[31:21], the 11-bit opcode feeding the control unit.

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, DRAIN.
REQ-016 SHALL drive imem_req=1 in FETCH and DRAIN and 0 in HOLD.
REQ-017 SHALL drive imem_addr from a dedicated register, held stable from req assertion until the acking cycle.
REQ-018 In FETCH with imem_ack=1 and no redirect: SHALL capture rdata into out_instr, imem_addr into out_pc, set out_valid=1, set pc=imem_addr+4, and go to HOLD.
REQ-019 In FETCH without ack: SHALL stay in FETCH.
REQ-020 In HOLD with out_ready=1: SHALL clear out_valid and go to FETCH; the next request is issued the following cycle.
REQ-021 In HOLD with out_ready=0: SHALL keep all outputs unchanged.
REQ-022 Redirect SHALL have priority over all other events and SHALL clear out_valid the same edge.
REQ-023 Redirect in FETCH with ack in the same cycle: SHALL discard rdata, load pc=redirect_pc, and stay in FETCH.
REQ-024 Redirect in FETCH without ack: SHALL store redirect_pc as pending and go to DRAIN; imem_addr is unchanged.
REQ-025 In DRAIN: SHALL discard data on ack, move the pending target to imem_addr, and go to FETCH.
REQ-026 Further redirects in DRAIN: SHALL overwrite the pending target, last one wins; a redirect in the same cycle as the ack SHALL take precedence.
REQ-027 Redirect in HOLD: SHALL drop the held instruction, load pc=redirect_pc, and go to FETCH.
REQ-028 SHALL force redirect_pc[1:0] to 2'b00.
REQ-029 PC increment SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-030 A redirect and out_ready in the same HOLD cycle SHALL be treated as a redirect; the instruction counts as not consumed.
REQ-031 Minimum throughput is one instruction per 2 cycles with zero-wait memory.

Reset
REQ-032 On rst_n=0, SHALL immediately set state=FETCH, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, pending target=0.
REQ-033 imem_req SHALL be 0 while rst_n=0 and SHALL assert on the first clock edge after release.
REQ-034 Reset during an outstanding request SHALL abandon it; the memory system is also reset.

Structure
REQ-035 The shared package SHALL hold PC_W=64, INSTR_W=32, OPCODE_W=11, OPCODE_MSB=31, OPCODE_LSB=21, the FSM state typedef, and the PC increment constant 4.
REQ-036 The 64-bit +4 incrementer is the single natural sub-module, pc_adder; no other sub-modules.

Verification
REQ-037 Reset release, RESET_PC=0, zero-wait ack -> addr 0,4,8 issued; out_pc 0,4,8; out_opcode = instr[31:21].
REQ-038 LDUR word 32'hF8400000 fetched -> out_opcode=11'h7C2; held while out_ready=0 for 5 cycles.
REQ-039 Redirect to 0x100 while a 3-cycle-latency request to 0x8 is pending -> 0x8 data dropped; next imem_addr=0x100; out_valid stays 0.
REQ-040 Redirect to 0x40 in the same cycle as the ack -> data dropped; next request is 0x40.
REQ-041 Two redirects in DRAIN (0x200, then 0x300) -> next fetch is 0x300; redirect_pc=0x302 -> fetch 0x300.
REQ-042 pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0; rst_n low mid-HOLD -> out_valid=0 immediately.
